// File: rtl/alu_8_arbiter.sv
// Shares one combinational alu_8 between two requesters (R0 datapath, R1 address unit), round-robin with lock.
// Latency: handshake at edge k -> alu_* valid after edge k, rspN_valid pulses after edge k+1.
// Backpressure: never stalls; grant is combinational, responses must be consumed the cycle they pulse.
`timescale 1ns/1ps
module alu_8_arbiter #(
  parameter int WIDTH       = 8,
  parameter int OPW         = 4,
  parameter int FIRST_GRANT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_lock,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_opcode,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_lock,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_opcode,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_opcode,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy
);

  // last_grant starts on the loser so FIRST_GRANT wins the first contended cycle
  localparam logic RST_LAST = (FIRST_GRANT == 0);

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_R0   = 2'd1,
    LOCK_R1   = 2'd2
  } lock_t;

  lock_t lock_q, lock_d;
  logic  last_grant;
  logic  grant0, grant1;
  logic  s1_valid;
  logic  s1_id;

  // Grant selection: lock owner first, then the single requester, then round-robin
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (lock_q)
      LOCK_R0: grant0 = req0_valid;
      LOCK_R1: grant1 = req1_valid;
      default: begin
        if (req0_valid && req1_valid) begin
          grant0 = last_grant;
          grant1 = !last_grant;
        end else begin
          grant0 = req0_valid;
          grant1 = req1_valid;
        end
      end
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Lock next state: only the handshaking requester can take or release the lock
  always_comb begin
    lock_d = lock_q;
    if (grant0) begin
      lock_d = req0_lock ? LOCK_R0 : LOCK_NONE;
    end else if (grant1) begin
      lock_d = req1_lock ? LOCK_R1 : LOCK_NONE;
    end
  end

  // Lock owner and round-robin pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q     <= LOCK_NONE;
      last_grant <= RST_LAST;
    end else begin
      lock_q <= lock_d;
      if (grant0) begin
        last_grant <= 1'b0;
      end else if (grant1) begin
        last_grant <= 1'b1;
      end
    end
  end

  // Stage 1: capture the winner's operands into the ALU input registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      s1_valid   <= 1'b0;
      s1_id      <= 1'b0;
    end else begin
      s1_valid <= grant0 | grant1;
      s1_id    <= grant1;
      if (grant0) begin
        alu_a      <= req0_a;
        alu_b      <= req0_b;
        alu_opcode <= req0_opcode;
      end else if (grant1) begin
        alu_a      <= req1_a;
        alu_b      <= req1_b;
        alu_opcode <= req1_opcode;
      end
    end
  end

  // Stage 2: register the ALU result and route it to the issuing requester
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
    end else begin
      rsp0_valid <= s1_valid & !s1_id;
      rsp1_valid <= s1_valid & s1_id;
      if (s1_valid && !s1_id) begin
        rsp0_data <= alu_out;
      end
      if (s1_valid && s1_id) begin
        rsp1_data <= alu_out;
      end
    end
  end

  assign busy = s1_valid | rsp0_valid | rsp1_valid;

endmodule

// File: tb/tb_alu_8_arbiter.sv
// Randomized bench for alu_8_arbiter with a transaction-level reference model and an alu_8 stand-in.
// Inputs driven on the falling edge; outputs compared 1 time unit after the rising edge.
`timescale 1ns/1ps
module tb_alu_8_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req0_lock;
  logic [7:0] req0_a, req0_b;
  logic [3:0] req0_opcode;
  logic       rsp0_valid;
  logic [7:0] rsp0_data;
  logic       req1_valid, req1_ready, req1_lock;
  logic [7:0] req1_a, req1_b;
  logic [3:0] req1_opcode;
  logic       rsp1_valid;
  logic [7:0] rsp1_data;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [3:0] alu_opcode;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_8_arbiter #(.WIDTH(8), .OPW(4), .FIRST_GRANT(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_lock(req0_lock),
    .req0_a(req0_a), .req0_b(req0_b), .req0_opcode(req0_opcode),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_lock(req1_lock),
    .req1_a(req1_a), .req1_b(req1_b), .req1_opcode(req1_opcode),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .busy(busy)
  );

  // alu_8 stand-in: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not a, 6 shl, 7 shr
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ~a;
      4'd6: return a << 1;
      4'd7: return a >> 1;
      default: return 8'h00;
    endcase
  endfunction

  always_comb alu_out = alu_fn(alu_a, alu_b, alu_opcode);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: transaction-level view of who owns the ALU and which results are due when
  typedef struct {
    int         id;
    logic [7:0] data;
    int         due;
  } item_t;

  item_t      pend[$];
  int         m_lock;   // -1 none, else owner index
  int         m_last;   // requester granted most recently
  int         cyc;
  logic [7:0] m_a, m_b;
  logic [3:0] m_op;
  logic [7:0] m_data [2];

  task automatic model_reset();
    pend.delete();
    m_lock    = -1;
    m_last    = 1;
    m_a       = 8'h00;
    m_b       = 8'h00;
    m_op      = 4'h0;
    m_data[0] = 8'h00;
    m_data[1] = 8'h00;
  endtask

  task automatic step(input logic v0, input logic l0, input logic [7:0] a0, input logic [7:0] b0,
                      input logic [3:0] o0, input logic v1, input logic l1, input logic [7:0] a1,
                      input logic [7:0] b1, input logic [3:0] o1);
    logic  g0, g1, e0, e1, busy_e;
    item_t it;
    @(negedge clk);
    req0_valid = v0; req0_lock = l0; req0_a = a0; req0_b = b0; req0_opcode = o0;
    req1_valid = v1; req1_lock = l1; req1_a = a1; req1_b = b1; req1_opcode = o1;
    #1;
    if (m_lock == 0) begin
      g0 = v0; g1 = 1'b0;
    end else if (m_lock == 1) begin
      g0 = 1'b0; g1 = v1;
    end else if (v0 && v1) begin
      g0 = (m_last == 1); g1 = !g0;
    end else begin
      g0 = v0; g1 = v1;
    end
    check("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
    check("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
    @(posedge clk);
    cyc++;
    if (g0 || g1) begin
      it.id   = g0 ? 0 : 1;
      it.data = g0 ? alu_fn(a0, b0, o0) : alu_fn(a1, b1, o1);
      it.due  = cyc + 1;
      pend.push_back(it);
      m_a    = g0 ? a0 : a1;
      m_b    = g0 ? b0 : b1;
      m_op   = g0 ? o0 : o1;
      m_last = it.id;
      m_lock = (g0 ? l0 : l1) ? it.id : -1;
    end
    #1;
    busy_e = (pend.size() > 0);
    e0 = 1'b0;
    e1 = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      if (pend[0].id == 0) e0 = 1'b1; else e1 = 1'b1;
      m_data[pend[0].id] = pend[0].data;
      void'(pend.pop_front());
    end
    check("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, e0});
    check("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, e1});
    check("rsp0_data", {24'd0, rsp0_data}, {24'd0, m_data[0]});
    check("rsp1_data", {24'd0, rsp1_data}, {24'd0, m_data[1]});
    check("alu_a", {24'd0, alu_a}, {24'd0, m_a});
    check("alu_b", {24'd0, alu_b}, {24'd0, m_b});
    check("alu_opcode", {28'd0, alu_opcode}, {28'd0, m_op});
    check("busy", {31'd0, busy}, {31'd0, busy_e});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 8'h00, 4'h0, 0, 0, 8'h00, 8'h00, 4'h0);
  endtask

  // Asynchronous reset asserted mid-cycle, between a handshake edge and its response edge
  task automatic mid_reset();
    #1 rst = 1'b1;
    #1;
    check("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_alu_a", {24'd0, alu_a}, 32'd0);
    check("rst_rsp0_data", {24'd0, rsp0_data}, 32'd0);
    model_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic v0, v1, l0, l1;
    rst = 1'b1;
    req0_valid = 0; req0_lock = 0; req0_a = 0; req0_b = 0; req0_opcode = 0;
    req1_valid = 0; req1_lock = 0; req1_a = 0; req1_b = 0; req1_opcode = 0;
    cyc = 0;
    model_reset();
    #2;
    check("reset_alu_opcode", {28'd0, alu_opcode}, 32'd0);
    check("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single R0 add
    step(1, 0, 8'd7, 8'd7, 4'd0, 0, 0, 8'h00, 8'h00, 4'h0);
    idle(2);
    check("single_data", {24'd0, rsp0_data}, 32'd14);

    // Contention straight after reset: R0 first, then alternate
    step(1, 0, 8'd7, 8'd7, 4'd0, 0, 0, 8'h00, 8'h00, 4'h0);
    mid_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 8'd7, 8'd7, 4'd1, 1, 0, 8'h0D, 8'd7, 4'd2);
    idle(2);
    check("contend_r0_data", {24'd0, rsp0_data}, 32'h00);
    check("contend_r1_data", {24'd0, rsp1_data}, 32'h05);

    // Lock: R1 takes the lock, chains an unlocked op, then R0 gets in
    step(1, 0, 8'd1, 8'd2, 4'd0, 1, 1, 8'hCB, 8'h2B, 4'd3);
    step(1, 0, 8'd1, 8'd2, 4'd0, 1, 1, 8'hCB, 8'h2B, 4'd3);
    step(1, 0, 8'd1, 8'd2, 4'd0, 1, 0, 8'hCB, 8'h2B, 4'd3);
    step(1, 0, 8'd1, 8'd2, 4'd0, 1, 0, 8'hCB, 8'h2B, 4'd3);
    idle(2);
    check("lock_r1_data", {24'd0, rsp1_data}, 32'hEB);

    // Lock held by an idle owner starves R0
    step(1, 0, 8'd3, 8'd4, 4'd0, 1, 1, 8'h11, 8'h22, 4'd4);
    for (int i = 0; i < 3; i++) step(1, 0, 8'd3, 8'd4, 4'd0, 0, 0, 8'h00, 8'h00, 4'h0);
    step(1, 0, 8'd3, 8'd4, 4'd0, 1, 0, 8'h33, 8'h44, 4'd4);
    idle(5);

    // Randomized traffic with occasional mid-flight resets
    for (int i = 0; i < 3000; i++) begin
      v0 = ($urandom_range(0, 9) < 7);
      v1 = ($urandom_range(0, 9) < 7);
      l0 = ($urandom_range(0, 3) == 0);
      l1 = ($urandom_range(0, 3) == 0);
      step(v0, l0, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 8)),
           v1, l1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 8)));
      if (i % 700 == 699) mid_reset();
    end
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
